// File: rtl/hub75_fb_ctrl_pkg.sv
// Shared framebuffer geometry and controller state encoding for the HUB75 framebuffer controller.
package hub75_fb_ctrl_pkg;

  localparam int unsigned FbAddrW  = 14;
  localparam int unsigned FbDataW  = 20;
  localparam int unsigned FbDepth  = 16384;
  localparam logic [FbDataW-1:0] FbClearValue = '0;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StClear    = 2'd1,
    StSwapWait = 2'd2
  } fb_state_e;

endpackage

// File: rtl/hub75_fb_ctrl.sv
// Framebuffer write-port owner: host writes, back-bank clears and frame-aligned bank swaps.
module hub75_fb_ctrl
  import hub75_fb_ctrl_pkg::*;
#(
  parameter int unsigned        ADDR_W      = FbAddrW,
  parameter int unsigned        DATA_W      = FbDataW,
  parameter int unsigned        DEPTH       = FbDepth,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clear_req,
  output logic              clear_done,
  input  logic              swap_req,
  output logic              swap_done,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic              fb_we,
  output logic              selection,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_pend_q, clr_pend_d;
  logic              swap_pend_q, swap_pend_d;
  logic              sel_q, sel_d;
  logic              rdy_q;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_waddr_q, fb_waddr_d;
  logic [DATA_W-1:0] fb_wdata_q, fb_wdata_d;
  logic              clear_done_q, clear_done_d;
  logic              swap_fire_q, swap_fire_d;
  logic              swap_done_q, swap_done_d;
  logic              wr_fire;

  // rdy_q holds off host writes for the first cycle out of reset.
  assign wr_ready = (state_q == StIdle) && rdy_q && !rst;
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_pend_d   = clr_pend_q | clear_req;
    swap_pend_d  = swap_pend_q | swap_req;
    sel_d        = sel_q;
    fb_we_d      = 1'b0;
    fb_waddr_d   = fb_waddr_q;
    fb_wdata_d   = fb_wdata_q;
    clear_done_d = 1'b0;
    swap_fire_d  = 1'b0;
    swap_done_d  = swap_fire_q;

    unique case (state_q)
      StIdle: begin
        if (wr_fire) begin
          fb_we_d    = 1'b1;
          fb_waddr_d = wr_addr;
          fb_wdata_d = wr_data;
        end
        if (clr_pend_d) begin
          state_d    = StClear;
          clr_addr_d = '0;
          clr_pend_d = 1'b0;
        end else if (swap_pend_d) begin
          state_d = StSwapWait;
        end
      end
      StClear: begin
        fb_we_d    = 1'b1;
        fb_waddr_d = clr_addr_q;
        fb_wdata_d = CLEAR_VALUE;
        if (clr_addr_q == LastAddr) begin
          clear_done_d = 1'b1;
          state_d      = swap_pend_d ? StSwapWait : StIdle;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      StSwapWait: begin
        if (frame_start) begin
          sel_d       = ~sel_q;
          swap_pend_d = 1'b0;
          swap_fire_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      clr_addr_q   <= '0;
      clr_pend_q   <= 1'b0;
      swap_pend_q  <= 1'b0;
      sel_q        <= 1'b0;
      rdy_q        <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_waddr_q   <= '0;
      fb_wdata_q   <= '0;
      clear_done_q <= 1'b0;
      swap_fire_q  <= 1'b0;
      swap_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_pend_q   <= clr_pend_d;
      swap_pend_q  <= swap_pend_d;
      sel_q        <= sel_d;
      rdy_q        <= 1'b1;
      fb_we_q      <= fb_we_d;
      fb_waddr_q   <= fb_waddr_d;
      fb_wdata_q   <= fb_wdata_d;
      clear_done_q <= clear_done_d;
      swap_fire_q  <= swap_fire_d;
      swap_done_q  <= swap_done_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_waddr   = fb_waddr_q;
  assign fb_wdata   = fb_wdata_q;
  assign clear_done = clear_done_q;
  assign swap_done  = swap_done_q;
  assign selection  = sel_q;
  assign busy       = (state_q != StIdle) || clr_pend_q || swap_pend_q;

endmodule

// File: tb/tb_hub75_fb_ctrl.sv
// Randomized and directed bench for hub75_fb_ctrl against a cycle-level behavioural model.
module tb_hub75_fb_ctrl;

  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 20;
  localparam int unsigned DEP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clear_req = 1'b0;
  logic          swap_req = 1'b0;
  logic          wr_ready, clear_done, swap_done, fb_we, selection, busy;
  logic [AW-1:0] fb_waddr;
  logic [DW-1:0] fb_wdata;

  hub75_fb_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .DEPTH       (DEP),
    .CLEAR_VALUE (20'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .clear_req   (clear_req),
    .clear_done  (clear_done),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .fb_waddr    (fb_waddr),
    .fb_wdata    (fb_wdata),
    .fb_we       (fb_we),
    .selection   (selection),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = idle, 1 = clearing, 2 = waiting for a frame boundary.
  int            m_mode  = 0;
  int            m_left  = 0;
  bit            m_want_clear = 0;
  bit            m_want_swap  = 0;
  bit            m_sel   = 0;
  bit            m_alive = 0;
  bit            m_toggled = 0;
  bit            e_we = 0;
  bit            e_cd = 0;
  bit            e_sd = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit fs, input bit accepted,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input bit cr, input bit sr);
    if (r) begin
      m_mode = 0; m_left = 0; m_want_clear = 0; m_want_swap = 0; m_sel = 0;
      m_alive = 0; m_toggled = 0;
      e_we = 0; e_cd = 0; e_sd = 0; e_addr = '0; e_data = '0;
      return;
    end
    e_sd      = m_toggled;
    m_toggled = 0;
    e_we      = 0;
    e_cd      = 0;
    m_alive   = 1;
    if (accepted) begin
      e_we = 1; e_addr = wa; e_data = wd;
    end
    m_want_clear = m_want_clear | cr;
    m_want_swap  = m_want_swap | sr;
    if (m_mode == 0) begin
      if (m_want_clear) begin
        m_mode = 1; m_left = DEP; m_want_clear = 0;
      end else if (m_want_swap) begin
        m_mode = 2;
      end
    end else if (m_mode == 1) begin
      e_we   = 1;
      e_addr = AW'(int'(DEP) - m_left);
      e_data = '0;
      e_cd   = (m_left == 1);
      m_left--;
      if (m_left == 0) m_mode = m_want_swap ? 2 : 0;
    end else if (fs) begin
      m_sel = ~m_sel; m_want_swap = 0; m_toggled = 1; m_mode = 0;
    end
  endtask

  task automatic step(input bit r, input bit fs, input bit wv, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input bit cr, input bit sr);
    bit rdy;
    rst = r; frame_start = fs; wr_valid = wv; wr_addr = wa; wr_data = wd;
    clear_req = cr; swap_req = sr;
    #1;
    rdy = (m_mode == 0) && m_alive && !r;
    check_eq("wr_ready", 32'(wr_ready), 32'(rdy));
    model_update(r, fs, wv && rdy, wa, wd, cr, sr);
    @(posedge clk);
    #1;
    check_eq("fb_we", 32'(fb_we), 32'(e_we));
    check_eq("fb_waddr", 32'(fb_waddr), 32'(e_addr));
    check_eq("fb_wdata", 32'(fb_wdata), 32'(e_data));
    check_eq("clear_done", 32'(clear_done), 32'(e_cd));
    check_eq("swap_done", 32'(swap_done), 32'(e_sd));
    check_eq("selection", 32'(selection), 32'(m_sel));
    check_eq("busy", 32'(busy), 32'(m_mode != 0 || m_want_clear || m_want_swap));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    int we_cnt;
    int cd_cnt;
    int sd_cnt;

    // 1: reset, then a single host write
    step(1, 0, 0, '0, '0, 0, 0);
    step(1, 0, 0, '0, '0, 0, 0);
    idle(1);
    step(0, 0, 1, 14'h0123, 20'hABCDE, 0, 0);
    check_eq("t1_we", 32'(fb_we), 32'd1);
    check_eq("t1_waddr", 32'(fb_waddr), 32'h0123);
    check_eq("t1_wdata", 32'(fb_wdata), 32'hABCDE);

    // 2: full clear of the back bank, host writes refused meanwhile
    step(0, 0, 0, '0, '0, 1, 0);
    we_cnt = 0;
    cd_cnt = 0;
    for (int i = 0; i < int'(DEP); i++) begin
      step(0, 0, 1, AW'($urandom), DW'($urandom), 0, 0);
      we_cnt += int'(fb_we);
      cd_cnt += int'(clear_done);
    end
    check_eq("t2_we_cycles", 32'(we_cnt), 32'(DEP));
    check_eq("t2_done_pulses", 32'(cd_cnt), 32'd1);
    idle(2);

    // 3: swap served by a frame_start five cycles later
    step(0, 0, 0, '0, '0, 0, 1);
    idle(4);
    step(0, 1, 0, '0, '0, 0, 0);
    check_eq("t3_sel", 32'(selection), 32'd1);
    idle(3);

    // 5: reset mid-clear with a swap pending
    step(0, 0, 0, '0, '0, 1, 1);
    idle(8);
    step(1, 0, 0, '0, '0, 0, 0);
    check_eq("t5_we", 32'(fb_we), 32'd0);
    check_eq("t5_sel", 32'(selection), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    idle(3);

    // 4: clear + swap together; frame_start during the clear must not swap
    step(0, 0, 0, '0, '0, 1, 1);
    idle(3);
    step(0, 1, 0, '0, '0, 0, 0);
    idle(int'(DEP));
    check_eq("t4_sel_held", 32'(selection), 32'd0);
    step(0, 1, 0, '0, '0, 0, 0);
    check_eq("t4_sel", 32'(selection), 32'd1);
    idle(3);

    // 6: two swaps plus a duplicate request while waiting
    sd_cnt = 0;
    step(0, 0, 0, '0, '0, 0, 1);
    step(0, 0, 0, '0, '0, 0, 1);
    step(0, 1, 0, '0, '0, 0, 0);
    for (int i = 0; i < 4; i++) begin idle(1); sd_cnt += int'(swap_done); end
    step(0, 0, 0, '0, '0, 0, 1);
    idle(2);
    step(0, 1, 0, '0, '0, 0, 0);
    for (int i = 0; i < 6; i++) begin idle(1); sd_cnt += int'(swap_done); end
    step(0, 1, 0, '0, '0, 0, 0);
    idle(2);
    check_eq("t6_sel", 32'(selection), 32'd1);
    check_eq("t6_done_pulses", 32'(sd_cnt), 32'd2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           AW'($urandom), DW'($urandom), $urandom_range(0, 49) == 0,
           $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
